bus_arbiter: RTL and testbench

Two-master, three-slave arbiter for the serial system bus. It grants one master at a time and drives the mux select for the master-to-slave address/data/control lines. It also enables the one addressed slave input port and reclaims the bus on completion, request withdrawal or timeout. It sits between the master out ports and the slave in ports; arbitration is round-robin.

---
 rtl/bus_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of two masters a tenure on one of three slave ports.
// Every output is registered; a tenure ends on done, request withdrawal or timeout.
module bus_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic [1:0] m1_slave_sel,
  input  logic [1:0] m2_slave_sel,
  input  logic       m1_done,
  input  logic       m2_done,
  input  logic [2:0] slave_ready,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       bus_sel,
  output logic [2:0] slave_en,
  output logic       bus_busy,
  output logic       sel_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    GRANT      = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  localparam logic [9:0] TCNT_LAST = 10'(TIMEOUT - 1);

  state_t     state, state_nxt;
  // owner and last_master use the bus_sel sense: 0 = master 1, 1 = master 2
  logic       owner, owner_nxt;
  logic       last_master, last_master_nxt;
  logic [1:0] tsel, tsel_nxt;
  logic [9:0] tcnt, tcnt_nxt;
  logic       bus_sel_nxt;
  logic       sel_err_nxt;
  logic       timeout_nxt;

  logic       winner;
  logic [1:0] winner_sel;
  logic       owner_req;
  logic       owner_done;
  logic [3:0] ready_ext;

  assign owner_req  = owner ? m2_req : m1_req;
  assign owner_done = owner ? m2_done : m1_done;
  assign ready_ext  = {1'b0, slave_ready};
  assign winner     = (m1_req && m2_req) ? ~last_master : m2_req;
  assign winner_sel = winner ? m2_slave_sel : m1_slave_sel;

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_master_nxt = last_master;
    tsel_nxt        = tsel;
    tcnt_nxt        = tcnt;
    bus_sel_nxt     = bus_sel;
    sel_err_nxt     = 1'b0;
    timeout_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (m1_req || m2_req) begin
          owner_nxt   = winner;
          bus_sel_nxt = winner;
          tsel_nxt    = winner_sel;
          if (winner_sel == 2'd3) begin
            sel_err_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_READY;
          end
        end
      end
      WAIT_READY: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (ready_ext[tsel]) begin
          state_nxt = GRANT;
          tcnt_nxt  = '0;
        end
      end
      GRANT: begin
        tcnt_nxt = tcnt + 10'd1;
        // A completing owner takes priority over a coincident timeout
        if (owner_done || !owner_req) begin
          state_nxt = RELEASE;
        end else if (tcnt == TCNT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        last_master_nxt = owner;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_master <= 1'b1;
      tsel        <= 2'd0;
      tcnt        <= '0;
      bus_sel     <= 1'b0;
      sel_err     <= 1'b0;
      timeout     <= 1'b0;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      slave_en    <= 3'b000;
      bus_busy    <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_master <= last_master_nxt;
      tsel        <= tsel_nxt;
      tcnt        <= tcnt_nxt;
      bus_sel     <= bus_sel_nxt;
      sel_err     <= sel_err_nxt;
      timeout     <= timeout_nxt;
      m1_grant    <= (state_nxt == GRANT) && !owner_nxt;
      m2_grant    <= (state_nxt == GRANT) && owner_nxt;
      slave_en    <= (state_nxt == GRANT) ? (3'b001 << tsel_nxt) : 3'b000;
      bus_busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic compared against a tenure-level reference model.
module tb_bus_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_req, m2_req;
  logic [1:0] m1_slave_sel, m2_slave_sel;
  logic       m1_done, m2_done;
  logic [2:0] slave_ready;
  logic       m1_grant, m2_grant, bus_sel, bus_busy, sel_err, timeout;
  logic [2:0] slave_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m1_req(m1_req), .m2_req(m2_req),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
    .m1_done(m1_done), .m2_done(m2_done),
    .slave_ready(slave_ready),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .bus_sel(bus_sel),
    .slave_en(slave_en), .bus_busy(bus_busy), .sel_err(sel_err), .timeout(timeout)
  );

  // Reference model in tenure terms: masters are numbered 1 and 2, and a tenure
  // moves through waiting for its slave, holding the bus, and a turnaround cycle.
  bit m_wait, m_hold, m_turn, m_serr, m_tout, m_bsel;
  int m_owner, m_last, m_target, m_age;

  task automatic model_reset();
    m_wait = 0; m_hold = 0; m_turn = 0; m_serr = 0; m_tout = 0; m_bsel = 0;
    m_owner = 1; m_last = 2; m_target = 0; m_age = 0;
  endtask

  function automatic bit req_of(int m);
    return (m == 1) ? m1_req : m2_req;
  endfunction

  function automatic bit done_of(int m);
    return (m == 1) ? m1_done : m2_done;
  endfunction

  task automatic model_step();
    m_serr = 0;
    m_tout = 0;
    if (m_turn) begin
      m_last = m_owner;
      m_turn = 0;
    end else if (m_hold) begin
      m_age++;
      if (done_of(m_owner) || !req_of(m_owner)) begin
        m_hold = 0; m_turn = 1;
      end else if (m_age == TO) begin
        m_tout = 1; m_hold = 0; m_turn = 1;
      end
    end else if (m_wait) begin
      if (!req_of(m_owner)) m_wait = 0;
      else if (slave_ready[m_target]) begin
        m_wait = 0; m_hold = 1; m_age = 0;
      end
    end else if (m1_req || m2_req) begin
      if (m1_req && m2_req) m_owner = (m_last == 1) ? 2 : 1;
      else m_owner = m1_req ? 1 : 2;
      m_target = (m_owner == 1) ? int'(m1_slave_sel) : int'(m2_slave_sel);
      m_bsel = (m_owner == 2);
      if (m_target == 3) m_serr = 1;
      else m_wait = 1;
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [2:0] sen;
    sen = m_hold ? (3'b001 << m_target) : 3'b000;
    return {m_hold && m_owner == 1, m_hold && m_owner == 2, m_bsel, sen,
            m_wait || m_hold || m_turn, m_serr, m_tout};
  endfunction

  function automatic logic [8:0] dut_out();
    return {m1_grant, m2_grant, bus_sel, slave_en, bus_busy, sel_err, timeout};
  endfunction

  task automatic check_output(string name, logic [8:0] act, logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(logic r1, logic r2, logic [1:0] s1, logic [1:0] s2,
                                logic d1, logic d2, logic [2:0] rdy);
    m1_req = r1; m2_req = r2; m1_slave_sel = s1; m2_slave_sel = s2;
    m1_done = d1; m2_done = d2; slave_ready = rdy;
  endtask

  task automatic tick(string name);
    @(posedge clk);
    model_step();
    #1;
    check_output(name, dut_out(), model_out());
  endtask

  // Reset is raised between edges, so the outputs must clear without a clock
  task automatic do_reset(string name);
    reset = 1'b1;
    model_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0, 3'b000);
    #1;
    check_output(name, dut_out(), 9'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       r1, r2;
    logic [1:0] s1, s2;
    logic       d1, d2;
    logic [2:0] rdy;
    logic [8:0] exp;  // {m1_grant, m2_grant, bus_sel, slave_en, bus_busy, sel_err, timeout}
  } vec_t;

  vec_t vecs[21];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int count;
    int waited;
    int exp_owner;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b100, 9'b0_0_0_000_1_0_0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b100, 9'b1_0_0_100_1_0_0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b100, 9'b1_0_0_100_1_0_0};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 3'b100, 9'b0_0_0_000_1_0_0};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b100, 9'b0_0_0_000_0_0_0};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 3'b001, 9'b0_0_1_000_1_0_0};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 3'b001, 9'b0_1_1_001_1_0_0};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b001, 9'b0_0_1_000_1_0_0};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b001, 9'b0_0_1_000_0_0_0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 3'b001, 9'b0_0_1_000_0_1_0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 3'b000, 9'b0_0_1_000_1_0_0};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 3'b000, 9'b0_0_1_000_1_0_0};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 3'b000, 9'b0_0_1_000_0_0_0};
    vecs[13] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 3'b010, 9'b0_0_0_000_1_0_0};
    vecs[14] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 3'b010, 9'b1_0_0_010_1_0_0};
    vecs[15] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 3'b010, 9'b0_0_0_000_1_0_0};
    vecs[16] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 3'b010, 9'b0_0_0_000_0_0_0};
    vecs[17] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 3'b011, 9'b0_0_1_000_1_0_0};
    vecs[18] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 3'b011, 9'b0_1_1_001_1_0_0};
    vecs[19] = '{1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 3'b011, 9'b0_0_1_000_1_0_0};
    vecs[20] = '{1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 3'b011, 9'b0_0_1_000_0_0_0};

    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 3'b000);
    #2;
    do_reset("reset_state");

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(vecs[i].r1, vecs[i].r2, vecs[i].s1, vecs[i].s2,
                     vecs[i].d1, vecs[i].d2, vecs[i].rdy);
      tick("vec_model");
      check_output($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Both masters held: tenures must alternate starting with master 1
    do_reset("reset_rr");
    apply_stimulus(1, 1, 2'd0, 2'd2, 0, 0, 3'b111);
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      while (!(m1_grant || m2_grant) && waited < 10) begin
        tick("rr_wait");
        waited++;
      end
      exp_owner = (t % 2 == 0) ? 1 : 2;
      check_output($sformatf("rr_owner%0d", t), {7'b0, m1_grant, m2_grant},
                   (exp_owner == 1) ? 9'b10 : 9'b01);
      repeat (4) tick("rr_hold");
      if (exp_owner == 1) m1_done = 1'b1;
      else m2_done = 1'b1;
      tick("rr_done");
      m1_done = 1'b0;
      m2_done = 1'b0;
      check_output($sformatf("rr_release%0d", t), {7'b0, m1_grant, m2_grant}, 9'b00);
    end

    // Tenure with no done: forced off after TO grant cycles, pending master follows
    do_reset("reset_to");
    apply_stimulus(1, 1, 2'd0, 2'd1, 0, 0, 3'b111);
    tick("to_wait");
    tick("to_grant");
    check_output("to_m1_granted", {8'b0, m1_grant}, 9'd1);
    count = 0;
    for (int i = 0; i < 20 && m1_grant; i++) begin
      count++;
      tick("to_run");
    end
    check_output("to_cycles", 9'(count), 9'(TO));
    check_output("to_pulse", {8'b0, timeout}, 9'd1);
    tick("to_idle");
    check_output("to_single", {8'b0, timeout}, 9'd0);
    tick("to_m2_wait");
    tick("to_m2_grant");
    check_output("to_m2_next", {7'b0, m1_grant, m2_grant}, 9'b01);

    // Slave never ready: bus stays busy with no grant until the request drops
    do_reset("reset_nr");
    apply_stimulus(1, 0, 2'd1, 2'd0, 0, 0, 3'b101);
    repeat (20) tick("nr_wait");
    check_output("nr_busy", {7'b0, bus_busy, m1_grant}, 9'b10);
    m1_req = 1'b0;
    tick("nr_abort");
    check_output("nr_idle", {7'b0, bus_busy, m1_grant}, 9'b00);

    // Reset in the middle of a tenure, then master 1 must win the next tie
    do_reset("reset_mg0");
    apply_stimulus(1, 0, 2'd1, 2'd1, 0, 0, 3'b111);
    tick("mg_wait");
    tick("mg_grant");
    check_output("mg_granted", {8'b0, m1_grant}, 9'd1);
    do_reset("reset_mid_grant");
    apply_stimulus(1, 1, 2'd1, 2'd1, 0, 0, 3'b111);
    tick("mg_tie");
    check_output("mg_tie_m1", {8'b0, bus_sel}, 9'd0);
    tick("mg_tie_grant");
    check_output("mg_tie_grant_m1", {7'b0, m1_grant, m2_grant}, 9'b10);

    // Randomized traffic against the reference model
    do_reset("reset_rand");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) m1_req = ~m1_req;
      if ($urandom_range(0, 3) == 0) m2_req = ~m2_req;
      m1_slave_sel = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      m2_slave_sel = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      m1_done = ($urandom_range(0, 5) == 0);
      m2_done = ($urandom_range(0, 5) == 0);
      slave_ready = 3'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
